// File: rtl/switch_pkg.sv
// Shared constants and types for the switch debounce block.
// Holds bus width, per-bit debounce state and bench cycle count.
package switch_pkg;

  localparam int SWITCH_WIDTH        = 8;
  localparam int DEBOUNCE_CYCLES_SIM = 4;

  typedef enum logic {
    STABLE,
    SETTLING
  } db_state_t;

  // Counter must hold n-1; keep at least one bit.
  function automatic int cnt_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/debounce_bit.sv
// One switch bit: 2-flop synchronizer, settle counter and
// two-state FSM producing the registered debounced level.
module debounce_bit
  import switch_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic sw,
  output logic db,
  output logic upd
);

  localparam int CW = cnt_bits(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam bit ONE_SHOT = (DEBOUNCE_CYCLES == 1);

  logic          s1;
  logic          s2;
  logic [CW-1:0] cnt;
  db_state_t     state;

  // High when db will load s2 on the coming edge.
  always_comb begin
    upd = 1'b0;
    if (s2 != db) begin
      if (ONE_SHOT)
        upd = 1'b1;
      else if (state == SETTLING && cnt == LAST)
        upd = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      db    <= 1'b0;
      cnt   <= '0;
      state <= STABLE;
    end else begin
      s1 <= sw;
      s2 <= s1;
      unique case (state)
        STABLE: begin
          if (s2 != db) begin
            if (ONE_SHOT) begin
              db <= s2;
            end else begin
              state <= SETTLING;
              cnt   <= CW'(1);
            end
          end
        end
        SETTLING: begin
          if (s2 == db) begin
            cnt   <= '0;
            state <= STABLE;
          end else if (cnt == LAST) begin
            db    <= s2;
            cnt   <= '0;
            state <= STABLE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/switch_debounce.sv
// Debounces a bus of switches; optional edge pulses are enabled
// with macro SWITCH_DEBOUNCE_EDGE_EN.
module switch_debounce
  import switch_pkg::*;
#(
  parameter int WIDTH           = SWITCH_WIDTH,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] switch,
  output logic [WIDTH-1:0] switch_db,
`ifdef SWITCH_DEBOUNCE_EDGE_EN
  output logic [WIDTH-1:0] switch_rise,
  output logic [WIDTH-1:0] switch_fall,
`endif
  output logic             switch_chg
);

  logic [WIDTH-1:0] upd;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_bit (
      .clk(clk),
      .rst(rst),
      .sw (switch[i]),
      .db (switch_db[i]),
      .upd(upd[i])
    );
  end

  // Pulses land in the same cycle the new level appears.
  always_ff @(posedge clk) begin
    if (rst) begin
      switch_chg  <= 1'b0;
`ifdef SWITCH_DEBOUNCE_EDGE_EN
      switch_rise <= '0;
      switch_fall <= '0;
`endif
    end else begin
      switch_chg  <= |upd;
`ifdef SWITCH_DEBOUNCE_EDGE_EN
      switch_rise <= upd & ~switch_db;
      switch_fall <= upd & switch_db;
`else
`endif
    end
  end

endmodule

// File: tb/tb_switch_debounce.sv
// Directed and random checks of switch_debounce against an
// input-history window model.
module tb_switch_debounce;
  import switch_pkg::*;

  localparam int W  = SWITCH_WIDTH;
  localparam int DC = DEBOUNCE_CYCLES_SIM;
  localparam int HN = 4096;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] switch = '0;
  logic [W-1:0] switch_db;
  logic [W-1:0] switch_rise;
  logic [W-1:0] switch_fall;
  logic         switch_chg;

  always #5 clk = ~clk;

  switch_debounce #(
    .WIDTH(W),
    .DEBOUNCE_CYCLES(DC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .switch(switch),
    .switch_db(switch_db),
`ifdef SWITCH_DEBOUNCE_EDGE_EN
    .switch_rise(switch_rise),
    .switch_fall(switch_fall),
`endif
    .switch_chg(switch_chg)
  );

  int checks = 0;
  int errors = 0;

  // hist[k] = level the synchronizer saw at edge k (0 under reset)
  logic [W-1:0] hist [HN];
  int           e = 0;
  logic [W-1:0] m_db = '0;
  logic         m_chg = 1'b0;
  logic [W-1:0] m_rise = '0;
  logic [W-1:0] m_fall = '0;
  int           m_changes = 0;
  int           d_changes = 0;

  task automatic chk(input string tag, input logic [W-1:0] got,
                     input logic [W-1:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input logic [W-1:0] v, input logic r);
    logic [W-1:0] nd;
    logic         all_diff;
    switch = v;
    rst    = r;
    e++;
    hist[e] = r ? '0 : v;
    if (r) hist[e-1] = '0;
    @(posedge clk);
    if (r) begin
      nd = '0;
      m_chg  = 1'b0;
      m_rise = '0;
      m_fall = '0;
    end else begin
      nd = m_db;
      // s2 sample at edge e is hist[e-2]; need DC opposite samples
      for (int b = 0; b < W; b++) begin
        all_diff = (e - 1 - DC) >= 0;
        for (int j = 0; j < DC; j++)
          if (all_diff && hist[e-2-j][b] == m_db[b]) all_diff = 1'b0;
        if (all_diff) nd[b] = ~m_db[b];
      end
      m_chg  = (nd != m_db);
      m_rise = nd & ~m_db;
      m_fall = ~nd & m_db;
    end
    m_db = nd;
    if (m_chg) m_changes++;
    #1;
    if (switch_chg === 1'b1) d_changes++;
    chk("model_db", switch_db, m_db);
    chk("model_chg", {7'b0, switch_chg}, {7'b0, m_chg});
`ifdef SWITCH_DEBOUNCE_EDGE_EN
    chk("model_rise", switch_rise, m_rise);
    chk("model_fall", switch_fall, m_fall);
`endif
  endtask

  initial begin
    logic [W-1:0] rv;
    for (int i = 0; i < HN; i++) hist[i] = '0;

    // reset held, outputs cleared
    repeat (3) step(8'hFF, 1'b1);
    chk("rst_db", switch_db, 8'h00);
    chk("rst_chg", {7'b0, switch_chg}, 8'h00);

    // full-bus rise after 2 + DC edges
    for (int i = 1; i <= 2 + DC; i++) begin
      step(8'hFF, 1'b0);
      if (i < 2 + DC) begin
        chk("rise_hold_db", switch_db, 8'h00);
        chk("rise_hold_chg", {7'b0, switch_chg}, 8'h00);
      end else begin
        chk("rise_db", switch_db, 8'hFF);
        chk("rise_chg", {7'b0, switch_chg}, 8'h01);
`ifdef SWITCH_DEBOUNCE_EDGE_EN
        chk("rise_vec", switch_rise, 8'hFF);
`endif
      end
    end
    step(8'hFF, 1'b0);
    chk("rise_one_cycle", {7'b0, switch_chg}, 8'h00);

    // back to zero, then short glitch must be ignored
    repeat (10) step(8'h00, 1'b0);
    chk("fall_db", switch_db, 8'h00);
    repeat (3) step(8'h01, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step(8'h00, 1'b0);
      chk("glitch_db", switch_db, 8'h00);
      chk("glitch_chg", {7'b0, switch_chg}, 8'h00);
    end

    // bit 0 chatters, then settles high
    for (int i = 0; i < 50; i++) begin
      step((i % 2 == 0) ? 8'h01 : 8'h00, 1'b0);
      chk("chatter_chg", {7'b0, switch_chg}, 8'h00);
    end
    for (int i = 1; i <= 2 + DC; i++) begin
      step(8'h01, 1'b0);
      chk("chatter_db", switch_db, (i < 2 + DC) ? 8'h00 : 8'h01);
    end

    // multi-bit fall from FF to CD in one pulse
    repeat (8) step(8'hFF, 1'b0);
    chk("pre_cd_db", switch_db, 8'hFF);
    d_changes = 0;
    for (int i = 1; i <= 2 + DC; i++) step(8'hCD, 1'b0);
    chk("cd_db", switch_db, 8'hCD);
    chk("cd_chg", {7'b0, switch_chg}, 8'h01);
`ifdef SWITCH_DEBOUNCE_EDGE_EN
    chk("cd_fall", switch_fall, 8'h32);
    chk("cd_rise", switch_rise, 8'h00);
`endif
    step(8'hCD, 1'b0);
    chk("cd_pulses", d_changes[W-1:0], 8'd1);

    // reset mid-settle restarts the full latency
    repeat (2) step(8'h00, 1'b1);
    repeat (4) step(8'hFF, 1'b0);
    step(8'hFF, 1'b1);
    chk("midrst_db", switch_db, 8'h00);
    chk("midrst_chg", {7'b0, switch_chg}, 8'h00);
    for (int i = 1; i <= 2 + DC; i++) begin
      step(8'hFF, 1'b0);
      chk("midrst_rel", switch_db, (i < 2 + DC) ? 8'h00 : 8'hFF);
    end

    // random vectors, each held 10 cycles
    m_changes = 0;
    d_changes = 0;
    for (int n = 0; n < 100; n++) begin
      rv = W'($urandom);
      repeat (10) step(rv, 1'b0);
    end
    checks++;
    assert (d_changes === m_changes) else begin
      errors++;
      $error("FAIL rand_chg_count: got %0d expected %0d",
             d_changes, m_changes);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/switch_debounce.md
SWITCH_DEBOUNCE -- requirements
Module: switch_debounce

Interface
REQ-001 SHALL provide parameter WIDTH, default 8: number of switch inputs, matching the 8-bit switch/LED bus.
REQ-002 SHALL provide parameter DEBOUNCE_CYCLES, default 500000: consecutive stable clock samples needed to accept a new level; legal range is 1 or more.
REQ-003 SHALL provide port clk, input, 1 bit: single clock; all logic on its rising edge.
REQ-004 SHALL provide port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL provide port switch, input, WIDTH bits: raw, asynchronous, bouncing switch levels.
REQ-006 SHALL provide port switch_db, output, WIDTH bits: debounced, registered switch levels; feeds the downstream switch-to-LED stage.
REQ-007 SHALL provide port switch_chg, output, 1 bit: one-cycle pulse when any bit of switch_db changes.
REQ-008 SHALL provide ports switch_rise and switch_fall, output, WIDTH bits each, present only under SWITCH_DEBOUNCE_EDGE_EN (see Configuration).

Function
REQ-009 SHALL pass each switch bit through a 2-flop synchronizer (s1, then s2) before any other use.
REQ-010 SHALL keep one independent counter per bit, sized to hold DEBOUNCE_CYCLES-1, plus a two-state FSM per bit:
- STABLE: s2 equals switch_db.
- SETTLING: s2 differs from switch_db.
REQ-011 In STABLE, when s2 differs from switch_db, the bit SHALL move to SETTLING and set its counter to 1; if DEBOUNCE_CYCLES=1, it SHALL instead update switch_db immediately and stay in STABLE.
REQ-012 In SETTLING, if s2 differs and the counter is below DEBOUNCE_CYCLES-1, the counter SHALL increment by 1.
REQ-013 In SETTLING, if s2 differs and the counter equals DEBOUNCE_CYCLES-1, switch_db for that bit SHALL load s2, the counter SHALL clear, and the bit SHALL return to STABLE.
REQ-014 In SETTLING, if s2 equals switch_db (a glitch), the counter SHALL clear and the bit SHALL return to STABLE with switch_db unchanged.
REQ-015 Latency from a clean input edge to switch_db update SHALL be exactly 2 + DEBOUNCE_CYCLES clock edges.
REQ-016 Any glitch shorter than DEBOUNCE_CYCLES samples at s2 SHALL never alter switch_db.
REQ-017 switch_chg SHALL be registered and asserted for exactly the one cycle following any edge that changed at least one switch_db bit.
REQ-018 Bits changing in the same cycle SHALL each be handled independently, producing a single switch_chg pulse for that cycle.
REQ-019 The counter SHALL never wrap; counting terminates at DEBOUNCE_CYCLES-1.

Reset
REQ-020 While rst=1 at a clock edge, the block SHALL clear s1, s2, all counters, switch_db, switch_chg, switch_rise and switch_fall to 0, and set every FSM to STABLE.
REQ-021 Reset asserted mid-SETTLING SHALL abort the settling; after release, a held-high input SHALL need the full 2 + DEBOUNCE_CYCLES edges again.
REQ-022 The first edge with rst=0 SHALL behave as a normal sample edge.

Configuration
REQ-023 With macro SWITCH_DEBOUNCE_EDGE_EN defined, the block SHALL provide switch_rise and switch_fall:
- switch_rise[i] is a one-cycle registered pulse, coincident with switch_chg, when switch_db[i] goes 0 to 1.
- switch_fall[i] is the same for a 1 to 0 transition.
REQ-024 Without SWITCH_DEBOUNCE_EDGE_EN, those ports and their logic SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-025 Shared package switch_pkg SHALL hold:
- SWITCH_WIDTH = 8
- the debounce state enum (STABLE, SETTLING)
- DEBOUNCE_CYCLES_SIM = 4, the value used by benches
REQ-026 Per-bit synchronizer, counter and FSM SHALL live in sub-module debounce_bit, instantiated WIDTH times by a generate loop.
REQ-027 The top level SHALL hold only switch_chg and edge aggregation.

Verification (DEBOUNCE_CYCLES=4, SWITCH_DEBOUNCE_EDGE_EN defined)
REQ-028 Reset held, then switch=8'hFF held: switch_db stays 8'h00 for 5 edges, becomes 8'hFF on the 6th edge; switch_chg and switch_rise=8'hFF pulse for one cycle.
REQ-029 switch=8'h01 for 3 cycles, then back to 8'h00: switch_db stays 8'h00 and no pulse occurs.
REQ-030 Bit 0 toggles every cycle for 50 cycles, then settles at 1: switch_db[0] rises exactly 6 edges after settling; no earlier pulse occurs.
REQ-031 From 8'hFF, drive 8'b11001101: after 6 edges switch_db=8'hCD, switch_fall=8'h32, and a single switch_chg pulse occurs.
REQ-032 Drive 8'hFF, then assert rst after 4 edges for 1 cycle: outputs are 0; switch_db reaches 8'hFF 6 edges after rst deasserts.
REQ-033 Drive 100 random vectors, each held 10 cycles: switch_db matches a reference model (input stable for 4 or more s2 samples), and switch_chg matches the model's change count.
